apb_cmd_master: RTL and testbench

- APB requester that sits directly upstream of the peripheral register slave (mod_top) and drives its PADDR/PSELx/PENABLE/PWRITE/PWDATA bus.
- Accepts read/write commands on a valid/ready interface and buffers them in a small FIFO.
- Sequences each command through APB SETUP and ACCESS phases, then returns read data or a write acknowledge on a one-cycle response strobe.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_cmd_fifo.sv | 53 +++++
 rtl/apb_cmd_master.sv | 118 +++++++++++
 tb/tb_apb_cmd_master.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM encoding, slave register
// map and the packing of a queued command.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam logic [7:0] REG_RESET    = 8'd1;
   localparam logic [7:0] REG_PER_DATA = 8'd4;

   // A queued command is packed as {write, addr, wdata}, write in the MSB.
   function automatic int cmd_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Small synchronous show-ahead FIFO holding pending APB commands; the head
// entry is visible combinationally so the FSM can load it on the pop edge.
module apb_cmd_fifo #(
   parameter int width = 41,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] wdata,
   output logic [width-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(depth);

   logic [width-1:0] mem [depth];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (PTR_W+1)'(depth));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= wdata;
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: queues read/write commands, runs each through SETUP and
// ACCESS with a bounded wait, and reports completion on a one-cycle strobe.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int addrWidth     = 8,
   parameter int dataWidth     = 32,
   parameter int fifoDepth     = 4,
   parameter int timeoutCycles = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [addrWidth-1:0] cmd_addr,
   input  logic [dataWidth-1:0] cmd_wdata,
   output logic                 rsp_valid,
   output logic                 rsp_write,
   output logic [dataWidth-1:0] rsp_rdata,
   output logic                 rsp_timeout,
   output logic [addrWidth-1:0] PADDR,
   output logic                 PSELx,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [dataWidth-1:0] PWDATA,
   input  logic [dataWidth-1:0] PRDATA,
   input  logic                 PREADY
);

   localparam int CMD_W  = cmd_width(addrWidth, dataWidth);
   localparam int WAIT_W = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(timeoutCycles - 1);

   apb_state_t        state_reg;
   logic [WAIT_W-1:0] wait_reg;
   logic [CMD_W-1:0]  head;
   logic              full;
   logic              empty;
   logic              pop;
   logic              finish;
   logic              timeout_hit;

   assign cmd_ready   = !full;
   assign timeout_hit = (wait_reg == WAIT_LAST);
   assign finish      = (state_reg == ACCESS) && (PREADY || timeout_hit);
   // A completing ACCESS may load the next command directly (back-to-back).
   assign pop         = !empty && ((state_reg == IDLE) || finish);

   apb_cmd_fifo #(
      .width (CMD_W),
      .depth (fifoDepth)
   ) u_fifo (
      .clk   (PCLK),
      .rst   (PRESETn),
      .push  (cmd_valid),
      .pop   (pop),
      .wdata ({cmd_write, cmd_addr, cmd_wdata}),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         state_reg   <= IDLE;
         wait_reg    <= '0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PWRITE      <= 1'b0;
         PSELx       <= 1'b0;
         PENABLE     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_write   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (pop) {PWRITE, PADDR, PWDATA} <= head;
         case (state_reg)
            IDLE: begin
               if (!empty) begin
                  PSELx     <= 1'b1;
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               PENABLE   <= 1'b1;
               wait_reg  <= '0;
               state_reg <= ACCESS;
            end
            ACCESS: begin
               if (finish) begin
                  rsp_valid   <= 1'b1;
                  rsp_write   <= PWRITE;
                  rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
                  rsp_timeout <= !PREADY;
                  PENABLE     <= 1'b0;
                  if (!empty) begin
                     state_reg <= SETUP;
                  end else begin
                     PSELx     <= 1'b0;
                     state_reg <= IDLE;
                  end
               end else begin
                  wait_reg <= wait_reg + WAIT_W'(1);
               end
            end
            default: begin
               PSELx     <= 1'b0;
               PENABLE   <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: slave model with programmable wait
// states, a vector table, directed corner sequences and a random stream.
module tb_apb_cmd_master;
   import apb_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready;
   logic        rsp_valid, rsp_write, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [7:0]  PADDR;
   logic        PSELx, PENABLE, PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY = 1'b1;

   apb_cmd_master #(
      .addrWidth(8), .dataWidth(32), .fifoDepth(4), .timeoutCycles(16)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        w;
      logic [31:0] rdata;
      logic        to;
      int          acc;
      bit          stable;
      bit          psel;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        bw;
   } rsp_t;

   typedef struct {
      logic        w;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          stall;
      logic [31:0] exp_rdata;
      logic        exp_to;
      int          exp_acc;
   } vec_t;

   typedef struct {
      logic        w;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   int          stall_target = 0;
   bit          hold_ready = 1'b0;
   logic [31:0] slave_mem [256];
   logic [31:0] ref_mem [256];
   rsp_t        rsp_q[$];
   rsp_t        mon_r;
   int          acc_cnt = 0;
   int          stall_cnt = 0;
   int          psel_hi = 0;
   logic [7:0]  acc_addr = '0;
   logic [31:0] acc_wdata = '0;
   logic        acc_write = 1'b0;
   bit          acc_stable = 1'b0;
   bit          ready_now;

   assign PRDATA = slave_mem[PADDR];

   // Slave model and bus monitor, all evaluated on the falling edge.
   always @(negedge PCLK) begin
      if (PRESETn) begin
         PREADY    = 1'b1;
         stall_cnt = 0;
         acc_cnt   = 0;
         for (int i = 0; i < 256; i++) slave_mem[i] = '0;
      end else begin
         ready_now = hold_ready ? 1'b0 : !(PENABLE && stall_cnt < stall_target);
         PREADY = ready_now;
         if (PSELx) psel_hi++;
         if (rsp_valid) begin
            mon_r.w = rsp_write;     mon_r.rdata = rsp_rdata;
            mon_r.to = rsp_timeout;  mon_r.acc = acc_cnt;
            mon_r.stable = acc_stable; mon_r.psel = PSELx;
            mon_r.addr = acc_addr;   mon_r.wdata = acc_wdata;
            mon_r.bw = acc_write;
            rsp_q.push_back(mon_r);
            acc_cnt = 0;
         end
         if (PENABLE) begin
            if (acc_cnt == 0) begin
               acc_addr = PADDR; acc_wdata = PWDATA; acc_write = PWRITE;
               acc_stable = PSELx;
            end else if (PADDR !== acc_addr || PWDATA !== acc_wdata ||
                         PWRITE !== acc_write || !PSELx) begin
               acc_stable = 1'b0;
            end
            acc_cnt++;
            if (!ready_now) stall_cnt++;
            if (ready_now && PSELx && PWRITE) slave_mem[PADDR] = PWDATA;
         end else begin
            stall_cnt = 0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, output bit ok);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge PCLK);
         if (cmd_ready) ok = 1'b1;
         @(posedge PCLK); #1;
         if (ok) break;
      end
      cmd_valid = 1'b0;
      if (!ok) bound_fail("send_cmd");
   endtask

   task automatic wait_rsp(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (rsp_q.size() >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge PCLK); #1;
      end
      if (!ok && rsp_q.size() >= target) ok = 1'b1;
      if (!ok) bound_fail("wait_rsp");
   endtask

   initial begin
      bit    ok;
      int    base;
      int    rdy_seen;
      int    psel_base;
      rsp_t  r;
      vec_t  vecs[8];
      exp_t  eq[$];
      exp_t  e;

      vecs[0] = '{1'b1, REG_PER_DATA, 32'd144,        0,  32'd0,          1'b0, 1};
      vecs[1] = '{1'b0, REG_PER_DATA, 32'd0,          0,  32'd144,        1'b0, 1};
      vecs[2] = '{1'b0, REG_PER_DATA, 32'd0,          3,  32'd144,        1'b0, 4};
      vecs[3] = '{1'b1, 8'd8,         32'hDEADBEEF,   1,  32'd0,          1'b0, 2};
      vecs[4] = '{1'b0, 8'd8,         32'd0,          15, 32'hDEADBEEF,   1'b0, 16};
      vecs[5] = '{1'b0, 8'd8,         32'd0,          16, 32'd0,          1'b1, 16};
      vecs[6] = '{1'b1, 8'd8,         32'd5,          16, 32'd0,          1'b1, 16};
      vecs[7] = '{1'b0, 8'd8,         32'd0,          0,  32'hDEADBEEF,   1'b0, 1};
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;

      // Reset state
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_bus", {PSELx, PENABLE, PWRITE, PADDR, PWDATA}, 0);
      check("rst_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_rdata}, 0);
      @(posedge PCLK); #2;
      PRESETn = 1'b0;
      @(posedge PCLK); #1;

      // Latency: write REG_RESET <= 1 with an empty FIFO and no wait states
      send_cmd(1'b1, REG_RESET, 32'd1, ok);
      @(negedge PCLK);
      check("lat_n_psel", PSELx, 0);
      @(negedge PCLK);
      check("lat_n1_psel_en", {PSELx, PENABLE}, 2'b10);
      @(negedge PCLK);
      check("lat_n2_access", {PSELx, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 8'd1, 32'd1});
      @(negedge PCLK);
      check("lat_n3_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_rdata}, {3'b110, 32'd0});
      @(negedge PCLK);
      check("lat_n4_idle", {rsp_valid, PSELx, PENABLE}, 0);
      @(posedge PCLK); #1;

      // Vector table: one isolated transfer per entry
      for (int i = 0; i < 8; i++) begin
         base = rsp_q.size();
         stall_target = vecs[i].stall;
         send_cmd(vecs[i].w, vecs[i].addr, vecs[i].wdata, ok);
         wait_rsp(base + 1, 80, ok);
         if (ok) begin
            r = rsp_q[base];
            check($sformatf("vec%0d_write", i), r.w, vecs[i].w);
            check($sformatf("vec%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_timeout", i), r.to, vecs[i].exp_to);
            check($sformatf("vec%0d_access_len", i), r.acc, vecs[i].exp_acc);
            check($sformatf("vec%0d_stable", i), r.stable, 1);
            check($sformatf("vec%0d_paddr", i), r.addr, vecs[i].addr);
            if (vecs[i].w) check($sformatf("vec%0d_pwdata", i), r.wdata, vecs[i].wdata);
         end
         repeat (2) begin @(posedge PCLK); #1; end
      end
      stall_target = 0;

      // Timeout followed by a queued command that completes normally
      base = rsp_q.size();
      stall_target = 16;
      send_cmd(1'b0, 8'd8, 32'd0, ok);
      send_cmd(1'b0, REG_PER_DATA, 32'd0, ok);
      wait_rsp(base + 1, 60, ok);
      stall_target = 0;
      wait_rsp(base + 2, 40, ok);
      if (ok) begin
         check("to_first_timeout", {rsp_q[base].to, rsp_q[base].rdata}, {1'b1, 32'd0});
         check("to_first_len", rsp_q[base].acc, 16);
         check("to_b2b_psel", rsp_q[base].psel, 1);
         check("to_next_rsp", {rsp_q[base+1].to, rsp_q[base+1].rdata}, {1'b0, 32'd144});
         check("to_next_len", rsp_q[base+1].acc, 1);
      end
      repeat (2) begin @(posedge PCLK); #1; end

      // FIFO full with the slave stalled, then back-to-back drain
      base = rsp_q.size();
      hold_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_cmd(1'b1, 8'(40 + i), 32'(8'hA0 + i), ok);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd45; cmd_wdata = 32'hA5;
      rdy_seen = 0;
      repeat (5) begin
         @(negedge PCLK);
         if (cmd_ready) rdy_seen++;
      end
      check("full_cmd_ready_high_cycles", rdy_seen, 0);
      check("full_in_access", {PSELx, PENABLE}, 2'b11);
      @(posedge PCLK); #1;
      hold_ready = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge PCLK);
         if (cmd_ready) ok = 1'b1;
         @(posedge PCLK); #1;
         if (ok) break;
      end
      cmd_valid = 1'b0;
      if (!ok) bound_fail("full_accept_6th");
      wait_rsp(base + 6, 100, ok);
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            r = rsp_q[base + i];
            check($sformatf("full%0d_order", i), {r.w, r.to, r.addr, r.wdata},
                  {1'b1, 1'b0, 8'(40 + i), 32'(8'hA0 + i)});
            check($sformatf("full%0d_psel_held", i), r.psel, (i < 5) ? 1 : 0);
         end
      end
      repeat (2) begin @(posedge PCLK); #1; end

      // Random stream against a memory-semantics reference model
      base = rsp_q.size();
      for (int i = 0; i < 60; i++) begin
         e.w     = 1'($urandom_range(0, 1));
         e.addr  = 8'(16 + $urandom_range(0, 15));
         e.wdata = $urandom;
         stall_target = int'($urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
         send_cmd(e.w, e.addr, e.wdata, ok);
         if (ok) begin
            e.rdata = e.w ? 32'd0 : ref_mem[e.addr];
            if (e.w) ref_mem[e.addr] = e.wdata;
            eq.push_back(e);
         end
      end
      wait_rsp(base + eq.size(), 3000, ok);
      stall_target = 0;
      for (int k = 0; k < eq.size() && base + k < rsp_q.size(); k++) begin
         r = rsp_q[base + k];
         check($sformatf("rnd%0d_rsp", k), {r.w, r.to, r.rdata}, {eq[k].w, 1'b0, eq[k].rdata});
         check($sformatf("rnd%0d_bus", k), {r.bw, r.addr, r.stable}, {eq[k].w, eq[k].addr, 1'b1});
         if (eq[k].w) check($sformatf("rnd%0d_pwdata", k), r.wdata, eq[k].wdata);
      end
      repeat (2) begin @(posedge PCLK); #1; end

      // Asynchronous reset during ACCESS with two commands queued
      base = rsp_q.size();
      hold_ready = 1'b1;
      send_cmd(1'b0, 8'd50, 32'd0, ok);
      send_cmd(1'b0, 8'd51, 32'd0, ok);
      send_cmd(1'b0, 8'd52, 32'd0, ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge PCLK);
         if (PENABLE) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("rst_reach_access");
      #2;
      PRESETn = 1'b1;
      #1;
      check("arst_bus_cleared", {PSELx, PENABLE, rsp_valid, PADDR}, 0);
      check("arst_cmd_ready", cmd_ready, 1);
      @(posedge PCLK);
      @(posedge PCLK); #2;
      PRESETn = 1'b0;
      hold_ready = 1'b0;
      psel_base = psel_hi;
      repeat (20) begin @(posedge PCLK); #1; end
      check("arst_no_responses", rsp_q.size() - base, 0);
      check("arst_no_transfers", psel_hi - psel_base, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "global timeout");
   end

endmodule
